module_display_scan: RTL and testbench

Two-digit multiplexed 7-segment scanner that sits directly downstream of the units/tens operand flip-flop stage. It consumes the registered BCD digits `op_u` and `op_d` and time-multiplexes them onto one shared segment bus and two digit-enable (anode) lines, at a fixed per-digit refresh rate. Each digit transition is separated by a one-cycle all-off guard to suppress ghosting. The block also performs leading-zero blanking and flags invalid BCD codes.

---
 rtl/module_display_scan_pkg.sv | 21 ++
 rtl/module_display_scan_bcd_7seg.sv | 17 +
 rtl/module_display_scan.sv | 114 +++++++++++
 tb/tb_module_display_scan.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/module_display_scan_pkg.sv
// Shared types and constants for the two-digit 7-segment scanner.
// Holds the FSM state enum, blank/dash patterns and digit table.
package pkg_display;

  typedef enum logic [1:0] {
    S_UNITS = 2'd0,
    S_GAP_D = 2'd1,
    S_TENS  = 2'd2,
    S_GAP_U = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Logical active-high patterns {g,f,e,d,c,b,a} for digits 0..9.
  localparam logic [6:0] DIGIT_PAT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/module_display_scan_bcd_7seg.sv
// Combinational BCD to 7-segment decoder (logical, active-high).
// Ports: bcd (4b in), pat (7b {g..a} out); codes above 9 give a dash.
module module_bcd_7seg
  import pkg_display::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] pat
);

  always_comb begin
    pat = SEG_DASH;
    for (int i = 0; i < 10; i++) begin
      if (bcd == 4'(i)) pat = DIGIT_PAT[i];
    end
  end

endmodule

// File: rtl/module_display_scan.sv
// Two-digit multiplexed 7-segment scanner with guard gaps and LZ blanking.
// Ports: clk, rst (sync high), op_u/op_d (BCD in), an[1:0], seg[6:0] out.
module module_display_scan
  import pkg_display::*;
#(
  parameter int CLK_FREQ_HZ    = 27_000_000,
  parameter int REFRESH_HZ     = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] op_u,
  input  logic [3:0] op_d,
  output logic [1:0] an,
  output logic [6:0] seg
);

  localparam int DIV = CLK_FREQ_HZ / REFRESH_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [1:0] AN_OFF =
    AN_ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [6:0] SEG_OFF =
    SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  if (DIV < 2) begin : g_bad_div
    $error("module_display_scan: DIV must be >= 2");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    dig_q, dig_d;
  logic [1:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [6:0]    pat;
  logic          tick;

  assign tick = (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_GAP_U;
      cnt_q   <= '0;
      dig_q   <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_GAP_U: state_d = S_UNITS;
      S_UNITS: if (tick) state_d = S_GAP_D;
      S_GAP_D: state_d = S_TENS;
      S_TENS:  if (tick) state_d = S_GAP_U;
      default: state_d = S_GAP_U;
    endcase
  end

  // Prescaler runs only in display slots; the shadow digit is
  // loaded on the edge that enters each slot.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_UNITS || state_q == S_TENS) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    dig_d = dig_q;
    if (state_d == S_UNITS && state_q != S_UNITS) dig_d = op_u;
    if (state_d == S_TENS && state_q != S_TENS)   dig_d = op_d;
  end

  module_bcd_7seg u_dec (
    .bcd (dig_d),
    .pat (pat)
  );

  // Outputs are computed for the state being entered so that the
  // registered pins line up with state_q.
  always_comb begin
    logic [1:0] an_l;
    logic [6:0] seg_l;
    an_l  = 2'b00;
    seg_l = SEG_BLANK;
    unique case (state_d)
      S_UNITS: begin
        an_l  = 2'b01;
        seg_l = pat;
      end
      S_TENS: begin
        an_l  = 2'b10;
        seg_l = (BLANK_LZ && dig_d == 4'd0) ? SEG_BLANK : pat;
      end
      default: begin
        an_l  = 2'b00;
        seg_l = SEG_BLANK;
      end
    endcase
    an_d  = AN_ACTIVE_LOW  ? ~an_l  : an_l;
    seg_d = SEG_ACTIVE_LOW ? ~seg_l : seg_l;
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_module_display_scan.sv
// Directed self-checking bench for module_display_scan (DIV=4).
// Second instance runs with leading-zero blanking disabled.
module tb_module_display_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] op_u = 4'd0;
  logic [3:0] op_d = 4'd0;
  logic [1:0] an, an_nb;
  logic [6:0] seg, seg_nb;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  logic [1:0] prev_an = 2'b11;

  logic [6:0] tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  always #5 clk = ~clk;

  module_display_scan #(
    .CLK_FREQ_HZ(100), .REFRESH_HZ(25),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .op_u(op_u), .op_d(op_d),
    .an(an), .seg(seg)
  );

  module_display_scan #(
    .CLK_FREQ_HZ(100), .REFRESH_HZ(25),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)
  ) u_dut_nb (
    .clk(clk), .rst(rst), .op_u(op_u), .op_d(op_d),
    .an(an_nb), .seg(seg_nb)
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic slot(input string tag, input logic [1:0] a,
                      input logic [6:0] s, input logic [6:0] snb,
                      input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, "_an"}, {6'd0, an}, {6'd0, a});
      chk({tag, "_seg"}, {1'b0, seg}, {1'b0, s});
      chk({tag, "_an_nb"}, {6'd0, an_nb}, {6'd0, a});
      chk({tag, "_seg_nb"}, {1'b0, seg_nb}, {1'b0, snb});
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("an_both_on", {7'd0, an == 2'b00}, 8'd0);
      chk("an_no_gap",
          {7'd0, prev_an != an && prev_an != 2'b11 && an != 2'b11},
          8'd0);
      prev_an <= an;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_u = 4'd3;
    op_d = 4'd7;
    rst  = 1'b1;
    step();
    step();
    chk("rst_an", {6'd0, an}, 8'h03);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    mon_en = 1'b1;
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      slot("f_u", 2'b10, ~7'h4F, ~7'h4F, 4);
      slot("f_gd", 2'b11, 7'h7F, 7'h7F, 1);
      slot("f_t", 2'b01, ~7'h07, ~7'h07, 4);
      slot("f_gu", 2'b11, 7'h7F, 7'h7F, 1);
    end

    op_u = 4'd5;
    op_d = 4'd0;
    do_reset();
    slot("lz_u", 2'b10, ~7'h6D, ~7'h6D, 4);
    slot("lz_gd", 2'b11, 7'h7F, 7'h7F, 1);
    slot("lz_t", 2'b01, 7'h7F, ~7'h3F, 4);

    op_u = 4'd0;
    op_d = 4'd12;
    do_reset();
    slot("u0_u", 2'b10, ~7'h3F, ~7'h3F, 4);
    slot("u0_gd", 2'b11, 7'h7F, 7'h7F, 1);
    slot("d12_t", 2'b01, ~7'h40, ~7'h40, 4);

    for (int c = 0; c < 16; c++) begin
      op_u = 4'(c);
      op_d = 4'd1;
      do_reset();
      step();
      chk($sformatf("sweep_%0d", c), {1'b0, seg}, {1'b0, ~tab[c]});
    end

    op_u = 4'd1;
    op_d = 4'd2;
    do_reset();
    slot("chg_u", 2'b10, ~7'h06, ~7'h06, 2);
    op_u = 4'd8;
    slot("chg_hold", 2'b10, ~7'h06, ~7'h06, 2);
    slot("chg_gd", 2'b11, 7'h7F, 7'h7F, 1);
    slot("chg_t", 2'b01, ~7'h5B, ~7'h5B, 4);
    slot("chg_gu", 2'b11, 7'h7F, 7'h7F, 1);
    slot("chg_new", 2'b10, ~7'h7F, ~7'h7F, 4);

    op_u = 4'd3;
    op_d = 4'd7;
    do_reset();
    slot("mr_u", 2'b10, ~7'h4F, ~7'h4F, 4);
    slot("mr_gd", 2'b11, 7'h7F, 7'h7F, 1);
    slot("mr_t", 2'b01, ~7'h07, ~7'h07, 2);
    rst = 1'b1;
    slot("mr_rst", 2'b11, 7'h7F, 7'h7F, 1);
    rst = 1'b0;
    slot("mr_u2", 2'b10, ~7'h4F, ~7'h4F, 4);
    slot("mr_gd2", 2'b11, 7'h7F, 7'h7F, 1);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
